// File: rtl/mac_stream_arbiter.sv
// Round-robin arbiter sharing one streaming MAC among NUM_REQ requesters; result returned tagged with owner id.
// Latency: grant registered 1 cycle after pending, then A/B pass-through is combinational; response registered once the MAC result is accepted.
// Backpressure: requester readies mirror MAC readies for the granted owner only; mac_out_ready only in WAIT_RES; rsp_* held until rsp_ready.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_a_* / req_b_*       : per-requester A/B streams (data packed, requester i at [i*W +: W])
//   mac_a_* / mac_b_*       : streams forwarded to the MAC for the current owner
//   mac_out_*               : MAC result channel, accepted only while waiting for the result
//   rsp_data/rsp_id/rsp_*   : registered result and owner id, valid-ready
//   grant_id, busy          : current owner (registered), high whenever not idle

module mac_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WA      = 16,
    parameter int WB      = 12,
    parameter int WO      = 20,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [NUM_REQ*WA-1:0] req_a_data,
    input  logic [NUM_REQ-1:0]    req_a_valid,
    input  logic [NUM_REQ-1:0]    req_a_last,
    output logic [NUM_REQ-1:0]    req_a_ready,

    input  logic [NUM_REQ*WB-1:0] req_b_data,
    input  logic [NUM_REQ-1:0]    req_b_valid,
    input  logic [NUM_REQ-1:0]    req_b_last,
    output logic [NUM_REQ-1:0]    req_b_ready,

    output logic [WA-1:0]         mac_a_data,
    output logic                  mac_a_valid,
    output logic                  mac_a_last,
    input  logic                  mac_a_ready,

    output logic [WB-1:0]         mac_b_data,
    output logic                  mac_b_valid,
    output logic                  mac_b_last,
    input  logic                  mac_b_ready,

    input  logic [WO-1:0]         mac_out_data,
    input  logic                  mac_out_valid,
    output logic                  mac_out_ready,

    output logic [WO-1:0]         rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,

    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 a_done;
    logic                 b_done;
    logic [IDW-1:0]       last_grant;
    logic [IDW-1:0]       pick_id;
    logic                 any_pend;
    logic [NUM_REQ-1:0]   pend;
    logic                 a_last_hs;
    logic                 b_last_hs;

    assign pend = req_a_valid | req_b_valid;

    // Round-robin pick: scanning from the highest offset down means the last
    // write wins, so the lowest offset from last_grant has priority.
    always_comb begin : arb
        int idx;
        idx      = 0;
        pick_id  = '0;
        any_pend = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (pend[idx]) begin
                pick_id  = IDW'(idx);
                any_pend = 1'b1;
            end
        end
    end

    assign a_last_hs = mac_a_valid & mac_a_ready & mac_a_last;
    assign b_last_hs = mac_b_valid & mac_b_ready & mac_b_last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_pend) state_nxt = STREAM;
            // The second last may arrive with or after the first one.
            STREAM:   if ((a_done | a_last_hs) & (b_done | b_last_hs)) state_nxt = WAIT_RES;
            WAIT_RES: if (mac_out_valid) state_nxt = RESP;
            RESP:     if (rsp_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic: pass-through of the owner's channels until each has seen its last
    always_comb begin
        req_a_ready   = '0;
        req_b_ready   = '0;
        mac_a_data    = '0;
        mac_a_valid   = 1'b0;
        mac_a_last    = 1'b0;
        mac_b_data    = '0;
        mac_b_valid   = 1'b0;
        mac_b_last    = 1'b0;
        mac_out_ready = (state == WAIT_RES);
        busy          = (state != IDLE);
        if (state == STREAM) begin
            if (!a_done) begin
                mac_a_data            = req_a_data[int'(grant_id)*WA +: WA];
                mac_a_valid           = req_a_valid[grant_id];
                mac_a_last            = req_a_last[grant_id];
                req_a_ready[grant_id] = mac_a_ready;
            end
            if (!b_done) begin
                mac_b_data            = req_b_data[int'(grant_id)*WB +: WB];
                mac_b_valid           = req_b_valid[grant_id];
                mac_b_last            = req_b_last[grant_id];
                req_b_ready[grant_id] = mac_b_ready;
            end
        end
    end

    // Grant, done flags and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        grant_id <= pick_id;
                        a_done   <= 1'b0;
                        b_done   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (a_last_hs) a_done <= 1'b1;
                    if (b_last_hs) b_done <= 1'b1;
                end
                WAIT_RES: begin
                    if (mac_out_valid) begin
                        rsp_data  <= mac_out_data;
                        rsp_id    <= grant_id;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_stream_arbiter.sv
module tb_mac_stream_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WA      = 16;
    localparam int WB      = 12;
    localparam int WO      = 20;
    localparam int IDW     = 2;

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ*WA-1:0] req_a_data;
    logic [NUM_REQ-1:0]    req_a_valid, req_a_last, req_a_ready;
    logic [NUM_REQ*WB-1:0] req_b_data;
    logic [NUM_REQ-1:0]    req_b_valid, req_b_last, req_b_ready;
    logic [WA-1:0]         mac_a_data;
    logic                  mac_a_valid, mac_a_last, mac_a_ready;
    logic [WB-1:0]         mac_b_data;
    logic                  mac_b_valid, mac_b_last, mac_b_ready;
    logic [WO-1:0]         mac_out_data;
    logic                  mac_out_valid, mac_out_ready;
    logic [WO-1:0]         rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_valid, rsp_ready;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    mac_stream_arbiter #(.NUM_REQ(NUM_REQ), .WA(WA), .WB(WB), .WO(WO), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_a_data(req_a_data), .req_a_valid(req_a_valid), .req_a_last(req_a_last), .req_a_ready(req_a_ready),
        .req_b_data(req_b_data), .req_b_valid(req_b_valid), .req_b_last(req_b_last), .req_b_ready(req_b_ready),
        .mac_a_data(mac_a_data), .mac_a_valid(mac_a_valid), .mac_a_last(mac_a_last), .mac_a_ready(mac_a_ready),
        .mac_b_data(mac_b_data), .mac_b_valid(mac_b_valid), .mac_b_last(mac_b_last), .mac_b_ready(mac_b_ready),
        .mac_out_data(mac_out_data), .mac_out_valid(mac_out_valid), .mac_out_ready(mac_out_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .grant_id(grant_id), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Requester beat stores: {last, data}
    logic [WA:0] a_mem [NUM_REQ][8];
    logic [WB:0] b_mem [NUM_REQ][8];
    int a_wr [NUM_REQ];
    int a_rd [NUM_REQ];
    int b_wr [NUM_REQ];
    int b_rd [NUM_REQ];

    // MAC model: pairs A and B beats in order, result = sum(a*b) >> 5 (Q.10 x Q.8 -> Q.13)
    logic [WA-1:0] ma [16];
    logic [WB-1:0] mb [16];
    int  m_a_n, m_b_n, done_a_n, done_b_n;
    bit  a_seen, b_seen, thr_b;

    // Scoreboard
    int            exp_id  [16];
    logic [WO-1:0] exp_dat [16];
    int            exp_n, rd_idx;
    int            n_checks, n_pass;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    endtask

    task automatic expect_rsp(input int id, input logic [WO-1:0] d);
        exp_id[exp_n]  = id;
        exp_dat[exp_n] = d;
        exp_n++;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            logic [WA:0] ea;
            logic [WB:0] eb;
            ea = (a_rd[i] < a_wr[i]) ? a_mem[i][a_rd[i]] : '0;
            eb = (b_rd[i] < b_wr[i]) ? b_mem[i][b_rd[i]] : '0;
            req_a_valid[i] = (a_rd[i] < a_wr[i]);
            req_b_valid[i] = (b_rd[i] < b_wr[i]);
            {req_a_last[i], req_a_data[i*WA +: WA]} = ea;
            {req_b_last[i], req_b_data[i*WB +: WB]} = eb;
        end
    endtask

    task automatic load(input int i, input int na, input logic [WA-1:0] av,
                        input int nb, input logic [WB-1:0] bv);
        if (a_rd[i] == a_wr[i]) begin a_rd[i] = 0; a_wr[i] = 0; end
        if (b_rd[i] == b_wr[i]) begin b_rd[i] = 0; b_wr[i] = 0; end
        for (int k = 0; k < na; k++) begin
            a_mem[i][a_wr[i]] = {(k == na - 1), av};
            a_wr[i]++;
        end
        for (int k = 0; k < nb; k++) begin
            b_mem[i][b_wr[i]] = {(k == nb - 1), bv};
            b_wr[i]++;
        end
        drive();
        #1;
    endtask

    // One clock: sample pre-edge handshakes, cross the edge, update stimulus and MAC model.
    task automatic tick();
        logic [NUM_REQ-1:0] ha, hb;
        logic               mah, mbh, moh, mal, mbl, rs;
        logic [WA-1:0]      mad;
        logic [WB-1:0]      mbd;
        logic [39:0]        acc;
        int                 np;
        ha  = req_a_valid & req_a_ready;
        hb  = req_b_valid & req_b_ready;
        mah = mac_a_valid & mac_a_ready;  mad = mac_a_data;  mal = mac_a_last;
        mbh = mac_b_valid & mac_b_ready;  mbd = mac_b_data;  mbl = mac_b_last;
        moh = mac_out_valid & mac_out_ready;
        rs  = reset;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ha[i]) a_rd[i]++;
            if (hb[i]) b_rd[i]++;
        end
        if (rs) begin
            m_a_n = 0; m_b_n = 0; a_seen = 0; b_seen = 0;
            mac_out_valid = 1'b0; mac_out_data = '0;
        end else begin
            if (mah) begin ma[m_a_n] = mad; m_a_n++; if (mal) a_seen = 1; end
            if (mbh) begin mb[m_b_n] = mbd; m_b_n++; if (mbl) b_seen = 1; end
            if (moh) begin
                done_a_n = m_a_n; done_b_n = m_b_n;
                m_a_n = 0; m_b_n = 0; a_seen = 0; b_seen = 0;
                mac_out_valid = 1'b0; mac_out_data = '0;
            end else if (a_seen && b_seen && !mac_out_valid) begin
                acc = '0;
                np  = (m_a_n < m_b_n) ? m_a_n : m_b_n;
                for (int k = 0; k < np; k++) acc += 40'(ma[k]) * 40'(mb[k]);
                mac_out_data  = WO'(acc >> 5);
                mac_out_valid = 1'b1;
            end
        end
        mac_b_ready = thr_b ? ~mac_b_ready : 1'b1;
        drive();
        #1;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (rd_idx < n && k < budget) begin tick(); k++; end
        check(nm, rd_idx, n);
    endtask

    task automatic check_idle_outputs(input string p);
        check({p, "_busy"},      32'(busy), 0);
        check({p, "_grant_id"},  32'(grant_id), 0);
        check({p, "_rsp"},       32'({rsp_valid, rsp_id, rsp_data}), 0);
        check({p, "_req_ready"}, 32'({req_a_ready, req_b_ready}), 0);
        check({p, "_mac_vl"},    32'({mac_a_valid, mac_a_last, mac_b_valid, mac_b_last, mac_out_ready}), 0);
        check({p, "_mac_data"},  32'({mac_a_data, mac_b_data}), 0);
    endtask

    // Monitor: compares each response at the cycle it is handshaken.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && rsp_ready) begin
                if (rd_idx < exp_n) begin
                    check("rsp_id",   32'(rsp_id),   32'(exp_id[rd_idx]));
                    check("rsp_data", 32'(rsp_data), 32'(exp_dat[rd_idx]));
                end else begin
                    check("rsp_unexpected", rd_idx, exp_n);
                end
                rd_idx++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        bit viol, viol2, got;
        int k;
        n_checks = 0; n_pass = 0; exp_n = 0; rd_idx = 0;
        m_a_n = 0; m_b_n = 0; done_a_n = 0; done_b_n = 0;
        a_seen = 0; b_seen = 0; thr_b = 0;
        for (int i = 0; i < NUM_REQ; i++) begin a_wr[i] = 0; a_rd[i] = 0; b_wr[i] = 0; b_rd[i] = 0; end
        reset = 1'b1; rsp_ready = 1'b1; mac_a_ready = 1'b1; mac_b_ready = 1'b1;
        mac_out_valid = 1'b0; mac_out_data = '0;
        req_a_data = '0; req_a_valid = '0; req_a_last = '0;
        req_b_data = '0; req_b_valid = '0; req_b_last = '0;
        tick(); tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // 1: requester 0 alone, 4x(1.0*1.0) = 4.0
        expect_rsp(0, 20'h08000);
        load(0, 4, 16'h0400, 4, 12'h100);
        tick();
        check("t1_busy", 32'(busy), 1);
        check("t1_grant", 32'(grant_id), 0);
        check("t1_ready0", 32'({req_a_ready, req_b_ready}), 32'h11);
        wait_rsp(1, 40, "t1_wait");
        check("t1_a_beats", done_a_n, 4);
        check("t1_b_beats", done_b_n, 4);
        check("t1_busy_fall", 32'(busy), 0);

        // 2: requesters 1 and 3 pending together -> 1 then 3
        expect_rsp(1, 20'h0C000);
        expect_rsp(3, 20'h06000);
        load(1, 2, 16'h0400, 2, 12'h300);
        load(3, 1, 16'h0C00, 1, 12'h100);
        tick();
        check("t2_grant_first", 32'(grant_id), 1);
        viol = 0; k = 0;
        while (rd_idx < 2 && k < 40) begin
            tick(); k++;
            if (req_a_ready[3] || req_b_ready[3]) viol = 1;
        end
        check("t2_req3_ready_low", 32'(viol), 0);
        wait_rsp(3, 40, "t2_wait");

        // 3: B last on beat 3 with throttled B ready, A last on beat 6; a spare B beat must stay put
        expect_rsp(2, 20'h0C000);
        thr_b = 1; mac_b_ready = 1'b0;
        load(2, 6, 16'h0400, 3, 12'h200);
        b_mem[2][b_wr[2]] = {1'b0, 12'h200};
        b_wr[2]++;
        drive(); #1;
        viol = 0; viol2 = 0; got = 0; k = 0;
        while (rd_idx < 4 && k < 60) begin
            tick(); k++;
            if (b_seen && (mac_b_valid || req_b_ready[2])) viol = 1;
            if (mac_out_ready && !a_seen) viol2 = 1;
            if (a_seen && !got) begin
                got = 1;
                check("t3_wait_after_a_last", 32'(mac_out_ready), 1);
                b_wr[2] = b_rd[2];
                drive(); #1;
            end
        end
        check("t3_wait", rd_idx, 4);
        check("t3_b_gated", 32'(viol), 0);
        check("t3_wait_early", 32'(viol2), 0);
        check("t3_a_beats", done_a_n, 6);
        check("t3_b_beats", done_b_n, 3);
        thr_b = 0; mac_b_ready = 1'b1;
        tick();

        // 4: both lasts in the same cycle, 2x(2.0*0.5) = 2.0
        expect_rsp(0, 20'h04000);
        load(0, 2, 16'h0800, 2, 12'h080);
        viol = 0; got = 0; k = 0;
        while (rd_idx < 5 && k < 40) begin
            tick(); k++;
            if (a_seen != b_seen) viol = 1;
            if (a_seen && b_seen && !got) begin
                got = 1;
                check("t4_wait_next", 32'(mac_out_ready), 1);
            end
        end
        check("t4_wait", rd_idx, 5);
        check("t4_same_cycle", 32'(viol), 0);
        check("t4_beats", 32'({8'(done_a_n), 8'(done_b_n)}), 32'h0202);

        // 5: response held while requester 2 waits
        expect_rsp(1, 20'h08000);
        expect_rsp(2, 20'h01000);
        rsp_ready = 1'b0;
        load(1, 1, 16'h0400, 1, 12'h400);
        k = 0;
        while (!rsp_valid && k < 30) begin tick(); k++; end
        check("t5_rsp_valid", 32'(rsp_valid), 1);
        load(2, 1, 16'h0200, 1, 12'h100);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t5_hold_data", 32'(rsp_data), 32'h08000);
            check("t5_hold_id", 32'(rsp_id), 1);
            check("t5_hold_misc", 32'({rsp_valid, mac_out_ready, req_a_ready[2], req_b_ready[2], grant_id}), 32'h21);
        end
        rsp_ready = 1'b1;
        wait_rsp(7, 40, "t5_wait");

        // 6: reset mid-stream after 2 beats, then 0 and 1 pending -> 0 first
        load(0, 4, 16'h0400, 4, 12'h100);
        k = 0;
        while (m_a_n < 2 && k < 30) begin tick(); k++; end
        check("t6_two_beats", m_a_n, 2);
        reset = 1'b1;
        tick();
        check_idle_outputs("t6_reset");
        for (int i = 0; i < NUM_REQ; i++) begin a_wr[i] = 0; a_rd[i] = 0; b_wr[i] = 0; b_rd[i] = 0; end
        expect_rsp(0, 20'h02000);
        expect_rsp(1, 20'h04000);
        load(0, 1, 16'h0400, 1, 12'h100);
        load(1, 1, 16'h0400, 1, 12'h200);
        reset = 1'b0;
        tick();
        check("t6_grant0", 32'({busy, grant_id}), 32'h4);
        wait_rsp(9, 60, "t6_wait");

        tick(); tick();
        check("all_rsp_seen", rd_idx, exp_n);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_stream_arbiter.md
Name: mac_stream_arbiter

Overview:
Shares one fixed_mac instance (A/B valid-ready-last streams in, one accumulated result out) among NUM_REQ requesters.
- Grants the MAC to one requester at a time, round-robin.
- Forwards that requester's A and B streams until both lasts are accepted.
- Captures the MAC result and returns it tagged with the requester id.
- Sits between the client datapaths and fixed_mac. Generates no fixed-point arithmetic itself.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WA, 16, A sample width (WI1+WF1)
WB, 12, B sample width (WI2+WF2)
WO, 20, MAC result width (WIO+WFO)
IDW, $clog2(NUM_REQ), requester id width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_a_data  in  NUM_REQ*WA  requester i occupies bits [i*WA +: WA]
req_a_valid / req_a_last  in  NUM_REQ  per-requester A valid / last
req_a_ready  out  NUM_REQ  per-requester A ready
req_b_data  in  NUM_REQ*WB  requester i occupies [i*WB +: WB]
req_b_valid / req_b_last  in  NUM_REQ  per-requester B valid / last
req_b_ready  out  NUM_REQ  per-requester B ready
mac_a_data / mac_a_valid / mac_a_last  out  WA/1/1  to MAC A channel
mac_a_ready  in  1  from MAC
mac_b_data / mac_b_valid / mac_b_last  out  WB/1/1  to MAC B channel
mac_b_ready  in  1  from MAC
mac_out_data  in  WO  MAC result
mac_out_valid  in  1  MAC result valid
mac_out_ready  out  1  result accept
rsp_data  out  WO  registered result
rsp_id  out  IDW  owner of rsp_data
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
grant_id  out  IDW  current owner (registered)
busy  out  1  high in any state except IDLE

Behaviour:
Reset:
- State goes to IDLE.
- rsp_valid, rsp_data, rsp_id, grant_id and busy are 0.
- All ready and mac_* valid/last outputs are 0.
- a_done and b_done are cleared.
- last_grant is set to NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation abandons the burst with no response. Any partial MAC state is the MAC's own reset concern; reset is shared.

Requester pending: req_a_valid[i] | req_b_valid[i].

IDLE:
- All readies are 0.
- If any requester is pending, pick the first pending one scanning last_grant+1, +2, ... with wrap.
- Register it into grant_id, clear a_done/b_done, and go to STREAM on the next cycle.
- Grant latency is 1 cycle from valid to the first possible forward.

STREAM:
- Combinational pass-through of the granted requester only.
- While !a_done: mac_a_* = granted req_a_*, and req_a_ready[g] = mac_a_ready.
- While !b_done: same for the B channel.
- Non-granted readies are 0.
- a_done is set on an A handshake (valid & ready) with last=1; b_done likewise for B.
- Once a channel is done, its mac valid and req ready are forced to 0 until the next grant.
- Both done (including both lasts in the same cycle, or the second arriving later) -> WAIT_RES.
- Unequal stream lengths are passed unchanged; handling them is the MAC's concern.
- mac_out_ready is 0.

WAIT_RES:
- mac_out_ready = 1.
- On mac_out_valid: register rsp_data = mac_out_data and rsp_id = grant_id, set rsp_valid = 1, go to RESP.

RESP:
- mac_out_ready = 0.
- rsp_* held stable until rsp_ready.
- On a rsp_valid & rsp_ready handshake: rsp_valid = 0, last_grant = grant_id, go to IDLE.
- Minimum turnaround between bursts is 2 cycles (RESP->IDLE->STREAM).

Other rules:
- mac_out_valid outside WAIT_RES is not accepted; it is held off by ready=0.
- A requester that drops valid mid-burst keeps the grant; there is no timeout or pre-emption.
- Fairness: with all requesters continuously pending, grants cycle 0,1,2,3,0,...

Test Plan:
1. Req0 only: 4 A beats 0x0400 (1.0) and 4 B beats 0x100 (1.0), last on beat 4, MAC model returns 0x08000 -> exactly 4 A and 4 B handshakes forwarded; rsp_data=0x08000, rsp_id=0; busy falls 1 cycle after the rsp handshake.
2. Req1 and req3 pending from the same cycle after reset -> grant order 1 then 3; req3 readies stay 0 until req1's response handshakes; rsp_id sequence 1, 3.
3. Uneven lasts: B_last on beat 3 with mac_b_ready throttled every 2nd cycle, A_last on beat 6 -> after b_done, mac_b_valid=0 and req_b_ready=0 while A continues; WAIT_RES is entered only after the A last handshake.
4. Both lasts handshaken in the same cycle -> WAIT_RES next cycle; no extra beats forwarded.
5. rsp_ready held 0 for 5 cycles while req2 is pending -> rsp_data/rsp_id stable; mac_out_ready=0; req2 not granted until the rsp handshake.
6. Reset asserted mid-STREAM after 2 beats -> next cycle all outputs are 0 and state is IDLE; after release with req0 and req1 pending, req0 is granted first.
